exp_norm_pipe: RTL and testbench
================================

Name: exp_norm_pipe

Overview:
- Pipelined normalisation stage for the VFPU add/mul datapath. Takes an unnormalised mantissa and a provisional exponent, counts leading zeros internally, left-shifts the mantissa and lowers the exponent by the count.
- Raises zero, underflow and overflow flags.
- Generalised over exponent and mantissa width, with a valid/ready handshake and a 2-stage pipeline.

Parameters:
- EXP_W, 10, exponent width; the exponent is two's complement signed.
- MAN_W, 48, mantissa width; bit MAN_W-1 is the target leading-one position.
- LZ_W, 7, leading-zero count width; must satisfy 2^LZ_W > MAN_W.
- EXP_MAX, 255, smallest exponent value that flags overflow.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept an input beat.
- exp_tmp  in  EXP_W  provisional exponent, signed.
- man_in  in  MAN_W  unnormalised mantissa.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the output beat.
- exp_norm  out  EXP_W  adjusted exponent.
- man_norm  out  MAN_W  normalised mantissa.
- lz_count  out  LZ_W  applied shift amount.
- zero  out  1  man_in was all zeros.
- uflow  out  1  exp_norm, read as signed, is <= 0 and zero=0.
- oflow  out  1  exp_norm, read as signed, is >= EXP_MAX.

Behaviour:
- Reset (async assert, sync release): out_valid=0 and both stage valid bits=0. exp_norm, man_norm, lz_count, zero, uflow, oflow all reset to 0. in_ready=1 one cycle after release.
- Handshake:
  - An input beat transfers when in_valid && in_ready.
  - An output beat transfers when out_valid && out_ready.
  - Once out_valid=1, all outputs hold stable until the transfer.
- Pipeline:
  - S1 registers exp_tmp, man_in and the LZ count.
  - S2 registers the shifted mantissa, adjusted exponent and flags.
  - Latency is exactly 2 cycles from input transfer to out_valid when not stalled. Throughput is 1 beat/cycle.
- Stall: stage k advances iff its successor is empty or being drained that cycle. in_ready = !s1_valid || s2_advance. This is combinational from out_ready; no skid buffer.
- LZ count: number of consecutive zeros from bit MAN_W-1 downward, range 0..MAN_W. man_in=0 gives lz=MAN_W.
- Arithmetic:
  - exp_norm = exp_tmp - zero-extended lz, truncated to EXP_W bits (wraps mod 2^EXP_W).
  - man_norm = man_in << lz, zero fill.
- Zero case: exp_norm=0, man_norm=0, zero=1, uflow=0, oflow=0, lz_count=MAN_W.
- Flag independence: uflow and oflow are never both 1. The exponent is not saturated unless DENORM_CLAMP_EN is defined.
- Simultaneous events:
  - With S1 and S2 full, out_ready=1 and in_valid=1, all three move in one cycle and no bubble is inserted.
  - With out_ready=0 and both stages full, in_ready=0.
- Reset mid-operation: in-flight beats are discarded, not emitted.

Optional Feature:
- Macro: DENORM_CLAMP_EN.
- Defined: shift = min(lz, exp_tmp-1) when exp_tmp is signed > 0, and shift = 0 when exp_tmp <= 0.
  - exp_norm = exp_tmp - shift, so exp_norm never drops below 1 through the shift.
  - When the clamp limits the shift, uflow is replaced by "denormal" (same port), meaning man_norm bit MAN_W-1 = 0.
  - lz_count reports the applied shift.
- Not defined: full lz shift as above, plain uflow semantics.

Test Plan:
- Reset / basic case: reset with clk running; release; exp_tmp=100, man_in=48'h0000_8000_0000 (lz=16), in_valid=1 for one beat, out_ready=1.
  - Response: out_valid high exactly 2 cycles after the transfer, exp_norm=84, man_norm=48'h8000_0000_0000, lz_count=16, all flags 0.
- Zero mantissa: man_in=0, exp_tmp=50 -> zero=1, exp_norm=0, man_norm=0, lz_count=48, uflow=0.
- Underflow: exp_tmp=10, man_in=48'h0000_0000_0001 (lz=47).
  - Without DENORM_CLAMP_EN: exp_norm=10'h3DB (-37), uflow=1.
  - With DENORM_CLAMP_EN: exp_norm=1, lz_count=9, denormal=1.
- Overflow: exp_tmp=300, man_in=48'h8000_0000_0000 -> exp_norm=300, lz=0, oflow=1.
- Backpressure:
  - Stimulus: 6 back-to-back beats with exp_tmp=1..6; out_ready=0 for cycles 3-7, then 1.
  - Response: in_ready=0 while both stages are full; no beat lost or duplicated; outputs emerge in order 1..6 and are stable during the stall.
- Reset mid-stream: assert rst with 2 beats in flight -> out_valid=0 immediately; neither beat appears after release.

Source files
------------

// File: rtl/exp_norm_pipe_if.sv
// Stream bundle for exp_norm_pipe: input beat (exponent + raw mantissa) and normalised output beat.
// slave = the normaliser, master = whatever feeds and drains it.
interface exp_norm_pipe_if #(
    parameter int EXP_W = 10,
    parameter int MAN_W = 48,
    parameter int LZ_W  = 7
);
    logic             in_valid;
    logic             in_ready;
    logic [EXP_W-1:0] exp_tmp;
    logic [MAN_W-1:0] man_in;

    logic             out_valid;
    logic             out_ready;
    logic [EXP_W-1:0] exp_norm;
    logic [MAN_W-1:0] man_norm;
    logic [LZ_W-1:0]  lz_count;
    logic             zero;
    logic             uflow;
    logic             oflow;

    modport slave (
        input  in_valid, exp_tmp, man_in, out_ready,
        output in_ready, out_valid, exp_norm, man_norm, lz_count, zero, uflow, oflow
    );

    modport master (
        output in_valid, exp_tmp, man_in, out_ready,
        input  in_ready, out_valid, exp_norm, man_norm, lz_count, zero, uflow, oflow
    );
endinterface

// File: rtl/exp_norm_pipe.sv
// Leading-zero normalise of mantissa/exponent with zero/underflow/overflow flags; DENORM_CLAMP_EN floors the exponent at 1.
// Latency 2 cycles, 1 beat/cycle; out_ready stalls propagate combinationally to in_ready (no skid buffer).
module exp_norm_pipe #(
    parameter int EXP_W   = 10,
    parameter int MAN_W   = 48,
    parameter int LZ_W    = 7,
    parameter int EXP_MAX = 255
) (
    input  logic              clk,
    input  logic              rst,
    exp_norm_pipe_if.slave    bus
);

    logic             r_init;

    logic             r_s1_vld;
    logic [EXP_W-1:0] r_s1_exp;
    logic [MAN_W-1:0] r_s1_man;
    logic [LZ_W-1:0]  r_s1_lz;

    logic             r_s2_vld;
    logic [EXP_W-1:0] r_s2_exp;
    logic [MAN_W-1:0] r_s2_man;
    logic [LZ_W-1:0]  r_s2_lz;
    logic             r_s2_zero;
    logic             r_s2_uflow;
    logic             r_s2_oflow;

    logic             w_s2_adv;
    logic             w_in_rdy;
    logic [LZ_W-1:0]  w_lz;

    logic [LZ_W-1:0]  w_shift;
    logic [EXP_W-1:0] w_exp;
    logic [MAN_W-1:0] w_man;
    logic [LZ_W-1:0]  w_lz_out;
    logic             w_zero;
    logic             w_uflow;
    logic             w_oflow;
`ifdef DENORM_CLAMP_EN
    logic             w_clamped;
    int               w_lim;
`endif

    // S2 drains when empty or when the consumer takes its beat; S1 refills in the same cycle.
    assign w_s2_adv = !r_s2_vld || bus.out_ready;
    assign w_in_rdy = r_init && (!r_s1_vld || w_s2_adv);

    // Lowest-to-highest scan so the topmost set bit decides the count.
    always_comb begin
        w_lz = LZ_W'(MAN_W);
        for (int i = 0; i < MAN_W; i++) begin
            if (bus.man_in[i]) begin
                w_lz = LZ_W'(MAN_W - 1 - i);
            end
        end
    end

    always_comb begin
        w_zero = (r_s1_man == '0);
`ifdef DENORM_CLAMP_EN
        w_lim     = int'($signed(r_s1_exp)) - 1;
        w_shift   = '0;
        w_clamped = 1'b0;
        if ($signed(r_s1_exp) > 0) begin
            if (int'(r_s1_lz) <= w_lim) begin
                w_shift = r_s1_lz;
            end else begin
                w_shift   = LZ_W'(w_lim);
                w_clamped = 1'b1;
            end
        end else begin
            w_clamped = (r_s1_lz != '0);
        end
`else
        w_shift = r_s1_lz;
`endif
        w_exp    = r_s1_exp - EXP_W'(w_shift);
        w_man    = r_s1_man << w_shift;
        w_lz_out = w_shift;
        w_oflow  = int'($signed(w_exp)) >= EXP_MAX;
        w_uflow  = (int'($signed(w_exp)) <= 0) && !w_zero;
`ifdef DENORM_CLAMP_EN
        // A limited shift leaves the leading one short of the top: report it as denormal.
        if (w_clamped) begin
            w_uflow = !w_man[MAN_W-1];
        end
`endif
        if (w_zero) begin
            w_exp    = '0;
            w_man    = '0;
            w_lz_out = LZ_W'(MAN_W);
            w_uflow  = 1'b0;
            w_oflow  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_init     <= 1'b0;
            r_s1_vld   <= 1'b0;
            r_s1_exp   <= '0;
            r_s1_man   <= '0;
            r_s1_lz    <= '0;
            r_s2_vld   <= 1'b0;
            r_s2_exp   <= '0;
            r_s2_man   <= '0;
            r_s2_lz    <= '0;
            r_s2_zero  <= 1'b0;
            r_s2_uflow <= 1'b0;
            r_s2_oflow <= 1'b0;
        end else begin
            r_init <= 1'b1;
            if (w_in_rdy) begin
                r_s1_vld <= bus.in_valid;
                if (bus.in_valid) begin
                    r_s1_exp <= bus.exp_tmp;
                    r_s1_man <= bus.man_in;
                    r_s1_lz  <= w_lz;
                end
            end
            if (w_s2_adv) begin
                r_s2_vld <= r_s1_vld;
                if (r_s1_vld) begin
                    r_s2_exp   <= w_exp;
                    r_s2_man   <= w_man;
                    r_s2_lz    <= w_lz_out;
                    r_s2_zero  <= w_zero;
                    r_s2_uflow <= w_uflow;
                    r_s2_oflow <= w_oflow;
                end
            end
        end
    end

    assign bus.in_ready  = w_in_rdy;
    assign bus.out_valid = r_s2_vld;
    assign bus.exp_norm  = r_s2_exp;
    assign bus.man_norm  = r_s2_man;
    assign bus.lz_count  = r_s2_lz;
    assign bus.zero      = r_s2_zero;
    assign bus.uflow     = r_s2_uflow;
    assign bus.oflow     = r_s2_oflow;

endmodule

// File: tb/tb_exp_norm_pipe.sv
// Directed bench for exp_norm_pipe: reset, normalise/zero/underflow/overflow vectors, backpressure and mid-stream reset.
module tb_exp_norm_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    exp_norm_pipe_if bus ();

    exp_norm_pipe dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [9:0] e, input logic [47:0] m);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.exp_tmp  = e;
        bus.man_in   = m;
        #1;
        while (!bus.in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("push_rdy", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [9:0] e, input logic [47:0] m,
                              input logic [6:0] lz, input logic z, input logic u, input logic o);
        int n = 0;
        while (!bus.out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_vld"},   64'(bus.out_valid), 64'd1);
        chk({tag, "_exp"},   64'(bus.exp_norm),  64'(e));
        chk({tag, "_man"},   64'(bus.man_norm),  64'(m));
        chk({tag, "_lz"},    64'(bus.lz_count),  64'(lz));
        chk({tag, "_zero"},  64'(bus.zero),      64'(z));
        chk({tag, "_uflow"}, 64'(bus.uflow),     64'(u));
        chk({tag, "_oflow"}, 64'(bus.oflow),     64'(o));
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cyc;
        int   k;
        int   nxt;
        int   seen;
        logic in_acc;
        logic out_acc;
        logic stalled;
        logic [9:0] held_exp;

        bus.in_valid  = 1'b0;
        bus.exp_tmp   = '0;
        bus.man_in    = '0;
        bus.out_ready = 1'b1;

        // Reset with the clock running
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready",  64'(bus.in_ready),  64'd0);
        chk("rst_exp_norm",  64'(bus.exp_norm),  64'd0);
        chk("rst_lz_count",  64'(bus.lz_count),  64'd0);
        rst = 1'b0;
        #1;
        chk("rel_in_ready_0", 64'(bus.in_ready), 64'd0);
        @(posedge clk); #1;
        chk("rel_in_ready_1", 64'(bus.in_ready), 64'd1);

        // Basic beat: exact 2-cycle latency
        push(10'd100, 48'h0000_8000_0000);
        chk("lat_cyc1_vld", 64'(bus.out_valid), 64'd0);
        @(posedge clk); #1;
        chk("lat_cyc2_vld", 64'(bus.out_valid), 64'd1);
        chk("basic_exp",  64'(bus.exp_norm), 64'd84);
        chk("basic_man",  64'(bus.man_norm), 64'h8000_0000_0000);
        chk("basic_lz",   64'(bus.lz_count), 64'd16);
        chk("basic_flags", 64'({bus.zero, bus.uflow, bus.oflow}), 64'd0);
        @(posedge clk); #1;
        chk("basic_drained", 64'(bus.out_valid), 64'd0);

        push(10'd50, 48'h0);
        expect_out("zero", 10'd0, 48'h0, 7'd48, 1'b1, 1'b0, 1'b0);

        push(10'd10, 48'h0000_0000_0001);
`ifdef DENORM_CLAMP_EN
        expect_out("uflow", 10'd1, 48'h0000_0000_0200, 7'd9, 1'b0, 1'b1, 1'b0);
`else
        expect_out("uflow", 10'h3DB, 48'h8000_0000_0000, 7'd47, 1'b0, 1'b1, 1'b0);
`endif

        push(10'd300, 48'h8000_0000_0000);
        expect_out("oflow", 10'd300, 48'h8000_0000_0000, 7'd0, 1'b0, 1'b0, 1'b1);

        // Backpressure: 6 beats exp 1..6, out_ready low in cycles 3..7
        k = 1; nxt = 1; seen = 0; stalled = 1'b0; held_exp = '0;
        for (cyc = 1; cyc <= 40 && nxt <= 6; cyc++) begin
            bus.out_ready = !(cyc >= 3 && cyc <= 7);
            bus.in_valid  = (k <= 6);
            bus.exp_tmp   = 10'(k);
            bus.man_in    = 48'h8000_0000_0000;
            #1;
            in_acc  = bus.in_valid && bus.in_ready;
            out_acc = bus.out_valid && bus.out_ready;
            if (cyc >= 3 && cyc <= 7) begin
                chk("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
                chk("bp_out_valid",    64'(bus.out_valid), 64'd1);
                if (stalled) chk("bp_stable", 64'(bus.exp_norm), 64'(held_exp));
                held_exp = bus.exp_norm;
                stalled  = 1'b1;
            end
            if (out_acc) begin
                chk("bp_order", 64'(bus.exp_norm), 64'(nxt));
                nxt++;
                seen++;
                stalled = 1'b0;
            end
            @(posedge clk); #1;
            if (in_acc) k++;
        end
        bus.in_valid = 1'b0;
        chk("bp_count", 64'(seen), 64'd6);
        chk("bp_no_extra", 64'(bus.out_valid), 64'd0);

        // Reset with two beats in flight
        bus.out_ready = 1'b0;
        push(10'd77, 48'h0000_0000_8000);
        push(10'd78, 48'h0000_0000_4000);
        chk("mid_vld_before", 64'(bus.out_valid), 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_vld_async", 64'(bus.out_valid), 64'd0);
        chk("mid_in_ready",  64'(bus.in_ready),  64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen++;
        end
        chk("mid_no_ghost", 64'(seen), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
